// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding,
// counter sizing and the legal WIDTH range.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational full-adder bit cell built from two half adders.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .x (a),
        .y (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .x (s0),
        .y (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder, building block of the serial bit cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a `sub` input for a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last;
    logic             cin;
    logic [WIDTH-1:0] b_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and inject a carry of one.
    assign cin  = sub;
    assign b_in = sub ? ~b : b;
`else
    assign cin  = 1'b0;
    assign b_in = b;
`endif

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);
    assign sum_nx = {bit_s, sum_sh};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= sum_nx[WIDTH-1:1];
            carry  <= bit_c;
            // Counter parks at the last index instead of wrapping.
            if (!last) cnt <= cnt + 1'b1;
            if (last) begin
                sum       <= sum_nx;
                carry_out <= bit_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       co;
    } vec_t;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Call at a negedge where the DUT can accept. Returns at the
    // negedge where done is seen. poke >= 0 pulses start at that
    // cycle of the run (it must be ignored).
    task automatic do_add(input logic [7:0] x, input logic [7:0] y,
                          input logic s, input logic [7:0] es,
                          input logic eco, input int poke);
        int cyc;
        start = 1'b1;
        a = x;
        b = y;
        sub = s;
        @(negedge clk);
        start = 1'b0;
        a = 8'h5A;
        b = 8'hC3;
        sub = ~s;
        check("busy_after_accept", busy, 1);
        cyc = 0;
        while (!done && cyc < 20) begin
            if (cyc == poke) begin
                start = 1'b1;
                a = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", cyc, 8);
        check("sum", sum, es);
        check("carry_out", carry_out, eco);
        check("busy_at_done", busy, 0);
    endtask

    vec_t tab[8];

    initial begin
        tab[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
        tab[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        tab[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        tab[3] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        tab[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
        tab[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
        tab[6] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        tab[7] = '{8'h3C, 8'hC4, 8'h00, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_co", carry_out, 0);

        for (int i = 0; i < 8; i++) begin
            do_add(tab[i].a, tab[i].b, 1'b0, tab[i].s, tab[i].co, -1);
            @(negedge clk);
            check("done_pulse", done, 0);
            check("sum_held", sum, tab[i].s);
            check("co_held", carry_out, tab[i].co);
        end

        // Back-to-back: second start issued in the DONE cycle.
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
        do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, -1);
        @(negedge clk);
        check("b2b_idle", busy, 0);

        // Start pulsed mid-run is ignored.
        do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 2);
        @(negedge clk);
        check("ignored_start_idle", busy, 0);
        check("ignored_start_sum", sum, 8'h46);

        // Reset after the 4th bit edge aborts the run.
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 0);
        check("abort_co", carry_out, 0);
        do_add(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, -1);
        @(negedge clk);

        // Reset mid-sim with held nonzero result.
        do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, -1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_busy", busy, 0);
        check("rst2_done", done, 0);
        check("rst2_sum", sum, 0);
        check("rst2_co", carry_out, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        do_add(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, -1);
        @(negedge clk);
        do_add(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, -1);
        @(negedge clk);
        do_add(8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, -1);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
